// File: rtl/alu_pkg.sv
// Shared ALU definitions: logic-unit opcodes and the output-buffer occupancy states.
package alu_pkg;

    localparam logic [2:0] LOGIC_AND  = 3'b000;
    localparam logic [2:0] LOGIC_OR   = 3'b001;
    localparam logic [2:0] LOGIC_NAND = 3'b010;
    localparam logic [2:0] LOGIC_NOR  = 3'b011;
    localparam logic [2:0] LOGIC_XOR  = 3'b100;
    localparam logic [2:0] LOGIC_XNOR = 3'b101;
    localparam logic [2:0] LOGIC_ANDN = 3'b110;
    localparam logic [2:0] LOGIC_NOTA = 3'b111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_state_e;

endpackage

// File: rtl/logic_unit_pipe_core.sv
// Purely combinational bitwise compute: opcode decode, result, zero flag and
// (with LOGIC_UNIT_PIPE_PARITY_EN) the even-parity bit of the result.
module logic_unit_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       fun_i,
    output logic [WIDTH-1:0] result_o,
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
    output logic             parity_o,
`endif
    output logic             zero_o
);

`ifdef LOGIC_UNIT_PIPE_PARITY_EN
    function automatic logic calc_parity(input logic [WIDTH-1:0] value);
        return ^value;
    endfunction

    assign parity_o = calc_parity(result_o);
`endif

    // Opcode decode into the WIDTH-bit result.
    always_comb begin
        result_o = {WIDTH{1'b0}};
        case (fun_i)
            LOGIC_AND:  result_o = a_i & b_i;
            LOGIC_OR:   result_o = a_i | b_i;
            LOGIC_NAND: result_o = ~(a_i & b_i);
            LOGIC_NOR:  result_o = ~(a_i | b_i);
            LOGIC_XOR:  result_o = a_i ^ b_i;
            LOGIC_XNOR: result_o = ~(a_i ^ b_i);
            LOGIC_ANDN: result_o = a_i & ~b_i;
            LOGIC_NOTA: result_o = ~a_i;
            default:    result_o = {WIDTH{1'b0}};
        endcase
    end

    assign zero_o = (result_o == {WIDTH{1'b0}});

endmodule

// File: rtl/logic_unit_pipe.sv
// Handshaked logic unit with a 2-entry output buffer (head/tail registers).
// Optional macro LOGIC_UNIT_PIPE_PARITY_EN adds a per-entry parity bit on Logic_Parity.
module logic_unit_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALU_FUN,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Logic_OUT,
    output logic             Logic_Zero,
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
    output logic             Logic_Parity,
`endif
    output logic             Logic_Flag
);

    generate
        if (DEPTH != 2) begin : g_bad_depth
            $error("logic_unit_pipe: DEPTH must be 2");
        end
    endgenerate

    logic [WIDTH-1:0] core_result_s;
    logic             core_zero_s;

    occ_state_e       state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [WIDTH-1:0] head_data_q, head_data_d;
    logic             head_zero_q, head_zero_d;
    logic [WIDTH-1:0] tail_data_q, tail_data_d;
    logic             tail_zero_q, tail_zero_d;
    logic             accept_s;
    logic             drain_s;

`ifdef LOGIC_UNIT_PIPE_PARITY_EN
    logic             core_parity_s;
    logic             head_par_q, head_par_d;
    logic             tail_par_q, tail_par_d;
`endif

    logic_unit_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i      (A),
        .b_i      (B),
        .fun_i    (ALU_FUN),
        .result_o (core_result_s),
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
        .parity_o (core_parity_s),
`endif
        .zero_o   (core_zero_s)
    );

    // in_ready is registered from state so out_ready never reaches it combinationally.
    assign accept_s = in_valid && in_ready_q;
    assign drain_s  = (state_q != ST_EMPTY) && out_ready;

    // Occupancy next-state and head/tail buffer updates; vacated slots clear to zero.
    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_zero_d = head_zero_q;
        tail_data_d = tail_data_q;
        tail_zero_d = tail_zero_q;
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
        head_par_d  = head_par_q;
        tail_par_d  = tail_par_q;
`endif
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_d     = ST_ONE;
                    head_data_d = core_result_s;
                    head_zero_d = core_zero_s;
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
                    head_par_d  = core_parity_s;
`endif
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && drain_s) begin
                    head_data_d = core_result_s;
                    head_zero_d = core_zero_s;
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
                    head_par_d  = core_parity_s;
`endif
                end else if (accept_s) begin
                    state_d     = ST_FULL;
                    tail_data_d = core_result_s;
                    tail_zero_d = core_zero_s;
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
                    tail_par_d  = core_parity_s;
`endif
                end else if (drain_s) begin
                    state_d     = ST_EMPTY;
                    head_data_d = {WIDTH{1'b0}};
                    head_zero_d = 1'b0;
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
                    head_par_d  = 1'b0;
`endif
                end else begin
                    state_d = ST_ONE;
                end
            end
            ST_FULL: begin
                if (drain_s) begin
                    state_d     = ST_ONE;
                    head_data_d = tail_data_q;
                    head_zero_d = tail_zero_q;
                    tail_data_d = {WIDTH{1'b0}};
                    tail_zero_d = 1'b0;
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
                    head_par_d  = tail_par_q;
                    tail_par_d  = 1'b0;
`endif
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d     = ST_EMPTY;
                head_data_d = {WIDTH{1'b0}};
                head_zero_d = 1'b0;
                tail_data_d = {WIDTH{1'b0}};
                tail_zero_d = 1'b0;
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
                head_par_d  = 1'b0;
                tail_par_d  = 1'b0;
`endif
            end
        endcase
        in_ready_d = (state_d != ST_FULL);
    end

    // State and buffer registers; synchronous active-low reset empties everything.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b0;
            head_data_q <= {WIDTH{1'b0}};
            head_zero_q <= 1'b0;
            tail_data_q <= {WIDTH{1'b0}};
            tail_zero_q <= 1'b0;
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
            head_par_q  <= 1'b0;
            tail_par_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            head_data_q <= head_data_d;
            head_zero_q <= head_zero_d;
            tail_data_q <= tail_data_d;
            tail_zero_q <= tail_zero_d;
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
            head_par_q  <= head_par_d;
            tail_par_q  <= tail_par_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = (state_q != ST_EMPTY);
    assign Logic_Flag = (state_q != ST_EMPTY);
    assign Logic_OUT  = head_data_q;
    assign Logic_Zero = head_zero_q;
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
    assign Logic_Parity = head_par_q;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe (WIDTH=8): directed scenarios plus random traffic vs. a queue model.
module tb_logic_unit_pipe;

    logic       CLK;
    logic       RST;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic [2:0] ALU_FUN;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Logic_OUT;
    logic       Logic_Zero;
    logic       Logic_Flag;
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
    logic       Logic_Parity;
`endif

    int         n_checks;
    int         n_errors;
    logic [7:0] exp_q[$];
    logic       m_rdy;

    logic_unit_pipe #(
        .WIDTH (8),
        .DEPTH (2)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .ALU_FUN    (ALU_FUN),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Logic_OUT  (Logic_OUT),
        .Logic_Zero (Logic_Zero),
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
        .Logic_Parity (Logic_Parity),
`endif
        .Logic_Flag (Logic_Flag)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_op(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
        case (f)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return ~(a & b);
            3'd3: return ~(a | b);
            3'd4: return a ^ b;
            3'd5: return ~(a ^ b);
            3'd6: return a & ~b;
            default: return ~a;
        endcase
    endfunction

    // One clock: drive inputs, advance the queue model at the edge, compare all outputs after it.
    task automatic cycle(input logic rst, input logic v, input logic ordy,
                         input logic [7:0] a, input logic [7:0] b, input logic [2:0] f);
        logic       acc;
        logic       drn;
        logic [7:0] res;
        logic [7:0] head;
        RST       = rst;
        in_valid  = v;
        out_ready = ordy;
        A         = a;
        B         = b;
        ALU_FUN   = f;
        acc = rst && v && m_rdy;
        drn = rst && ordy && (exp_q.size() != 0);
        res = ref_op(f, a, b);
        @(posedge CLK);
        #1;
        if (!rst) begin
            exp_q.delete();
            m_rdy = 1'b0;
        end else begin
            if (drn) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(res);
            m_rdy = (exp_q.size() < 2);
        end
        head = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
        chk("in_ready",   32'(in_ready),   32'(m_rdy));
        chk("out_valid",  32'(out_valid),  32'(exp_q.size() != 0));
        chk("Logic_Flag", 32'(Logic_Flag), 32'(exp_q.size() != 0));
        chk("Logic_OUT",  32'(Logic_OUT),  32'(head));
        chk("Logic_Zero", 32'(Logic_Zero), 32'((exp_q.size() != 0) && (head == 8'h00)));
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
        chk("Logic_Parity", 32'(Logic_Parity), 32'((exp_q.size() != 0) && (^head)));
`endif
    endtask

    initial begin
        logic [7:0] exp_ops [8];
        n_checks  = 0;
        n_errors  = 0;
        m_rdy     = 1'b0;
        RST       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = 8'h00;
        B         = 8'h00;
        ALU_FUN   = 3'd0;
        exp_ops = '{8'h0A, 8'hAF, 8'hF5, 8'h50, 8'hA5, 8'h5A, 8'hA0, 8'h55};

        // Reset, then a single XOR
        cycle(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 3'd0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        cycle(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 3'd0);
        chk("post_rst_in_ready", 32'(in_ready), 32'h1);
        cycle(1'b1, 1'b1, 1'b1, 8'hF0, 8'h3C, 3'b100);
        chk("t1_out",  32'(Logic_OUT),  32'h00CC);
        chk("t1_flag", 32'(Logic_Flag), 32'h1);
        cycle(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 3'd0);
        chk("t1_drained", 32'(out_valid), 32'h0);

        // All opcodes back-to-back
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 8'hAA, 8'h0F, 3'(i));
            chk("allops_out", 32'(Logic_OUT), 32'(exp_ops[i]));
        end
        cycle(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 3'd0);

        // Backpressure
        cycle(1'b1, 1'b1, 1'b0, 8'hFF, 8'h01, 3'b000);
        cycle(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 3'b001);
        chk("bp_full_in_ready", 32'(in_ready), 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 8'h12, 8'h34, 3'b100);
        chk("bp_head_hold", 32'(Logic_OUT),  32'h0001);
        chk("bp_head_zero", 32'(Logic_Zero), 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 8'h12, 8'h34, 3'b100);
        chk("bp_second", 32'(Logic_OUT),  32'h0000);
        chk("bp_zero",   32'(Logic_Zero), 32'h1);
        cycle(1'b1, 1'b1, 1'b1, 8'h12, 8'h34, 3'b100);
        chk("bp_third", 32'(Logic_OUT), 32'h0026);
        cycle(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 3'd0);

        // Simultaneous accept and drain in ONE
        for (int i = 0; i < 20; i++)
            cycle(1'b1, 1'b1, 1'b1, 8'($urandom), 8'($urandom), 3'($urandom));
        cycle(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 3'd0);

        // Reset with a full buffer
        cycle(1'b1, 1'b1, 1'b0, 8'h5A, 8'h0F, 3'b000);
        cycle(1'b1, 1'b1, 1'b0, 8'h5A, 8'h0F, 3'b001);
        cycle(1'b0, 1'b1, 1'b1, 8'h5A, 8'h0F, 3'b001);
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_out",   32'(Logic_OUT), 32'h0);
        chk("mid_rst_ready", 32'(in_ready),  32'h0);
        cycle(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 3'd0);
        chk("mid_rst_release", 32'(in_ready), 32'h1);

`ifdef LOGIC_UNIT_PIPE_PARITY_EN
        cycle(1'b1, 1'b1, 1'b1, 8'hFE, 8'h00, 3'b111);
        chk("par_out1", 32'(Logic_OUT),    32'h01);
        chk("par_bit1", 32'(Logic_Parity), 32'h1);
        cycle(1'b1, 1'b1, 1'b1, 8'hFC, 8'h00, 3'b111);
        chk("par_out2", 32'(Logic_OUT),    32'h03);
        chk("par_bit2", 32'(Logic_Parity), 32'h0);
        cycle(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 3'd0);
`endif

        // Random traffic with random stalls and occasional resets
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 2) != 0), 8'($urandom), 8'($urandom), 3'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
